// File: rtl/mp_addsub_seq_if.sv
// Request/result handshake bundle for mp_addsub_seq; W is the full operand width (M*K).
interface mp_addsub_seq_if #(parameter int W = 64);
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         cout;
  logic         v;
  logic         busy;

  modport master (
    output in_valid, sub, x, y, out_ready,
    input  in_ready, out_valid, out, cout, v, busy
  );

  modport slave (
    input  in_valid, sub, x, y, out_ready,
    output in_ready, out_valid, out, cout, v, busy
  );
endinterface

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/sub: one M-bit limb per cycle through a shared CLA, LSB first; optional `zero` flag via MP_ADDSUB_ZERO_FLAG_EN.
// Result valid K cycles after accept, held in DONE while out_ready=0; single outstanding op, in_ready only in IDLE.
module claAddSubGen #(
  parameter int M = 16
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [M-1:0] out,
  output logic         cout,
  output logic         v,
  output logic         g,
  output logic         p
);
  logic [M-1:0] w_bx;
  logic [M-1:0] w_gen;
  logic [M-1:0] w_prop;
  logic [M:0]   w_c;
  logic         w_gg;

  assign w_bx   = b ^ {M{sub}};
  assign w_gen  = a & w_bx;
  assign w_prop = a ^ w_bx;

  // Each carry is a flat sum of products over all lower generate/propagate terms.
  always_comb begin
    logic acc_t;
    logic pp_t;
    acc_t  = 1'b0;
    pp_t   = 1'b1;
    w_c    = '0;
    w_gg   = 1'b0;
    w_c[0] = cin ^ sub;
    for (int i = 0; i < M; i++) begin
      acc_t = 1'b0;
      pp_t  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc_t = acc_t | (pp_t & w_gen[j]);
        pp_t  = pp_t & w_prop[j];
      end
      if (i == M - 1) w_gg = acc_t;
      w_c[i+1] = acc_t | (pp_t & w_c[0]);
    end
  end

  assign out  = w_prop ^ w_c[M-1:0];
  assign cout = w_c[M] ^ sub;
  assign v    = w_c[M] ^ w_c[M-1];
  assign g    = w_gg;
  assign p    = &w_prop;
endmodule

module mp_addsub_seq #(
  parameter int M = 16,
  parameter int K = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mp_addsub_seq_if.slave    io_bus
`ifdef MP_ADDSUB_ZERO_FLAG_EN
  ,
  output logic              zero
`endif
);
  localparam int W  = M * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_live;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_sub;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_out;
  logic          r_cout;
  logic          r_v;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
  logic          r_zacc;
  logic          r_zero;
`endif

  logic [M-1:0]  w_a;
  logic [M-1:0]  w_b;
  logic [M-1:0]  w_sum;
  logic          w_cout;
  logic          w_v;
  logic          w_unused_g;
  logic          w_unused_p;

  assign w_a = r_x[r_idx*M +: M];
  assign w_b = r_y[r_idx*M +: M];

  // The adder re-inverts cin/cout when subtracting, so the stored value is a borrow.
  claAddSubGen #(.M(M)) u_cla (
    .a    (w_a),
    .b    (w_b),
    .sub  (r_sub),
    .cin  (r_carry),
    .out  (w_sum),
    .cout (w_cout),
    .v    (w_v),
    .g    (w_unused_g),
    .p    (w_unused_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_out   <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
      r_zacc  <= 1'b0;
      r_zero  <= 1'b0;
`endif
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid && r_live) begin
            r_x     <= io_bus.x;
            r_y     <= io_bus.y;
            r_sub   <= io_bus.sub;
            r_idx   <= '0;
            r_carry <= 1'b0;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
            r_zacc  <= 1'b1;
`endif
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_out[r_idx*M +: M] <= w_sum;
          r_carry             <= w_cout;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
          r_zacc              <= r_zacc & ~(|w_sum);
`endif
          if (r_idx == LAST) begin
            r_cout  <= w_cout;
            r_v     <= w_v;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
            r_zero  <= r_zacc & ~(|w_sum);
`endif
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = r_live && (r_state == S_IDLE);
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.out       = r_out;
  assign io_bus.cout      = r_cout;
  assign io_bus.v         = r_v;
`ifdef MP_ADDSUB_ZERO_FLAG_EN
  assign zero = r_zero;
`endif
endmodule
